// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;
    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 8;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: processor, VGA and dmem signals seen by the arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_q,
        output cpu_stall, cpu_rdata, cpu_rvalid, vga_gnt, vga_rdata, vga_rvalid,
               mem_addr, mem_data, mem_wren
    );
    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_q,
        input  cpu_stall, cpu_rdata, cpu_rvalid, vga_gnt, vga_rdata, vga_rvalid,
               mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: counts denied VGA cycles and raises force_vga at the limit
module dmem_arb_starve_ctr #(
    parameter int STARVE_MAX = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_vga_req,
    input  logic i_vga_gnt,
    output logic o_force_vga
);
    localparam logic [7:0] MAX = 8'(STARVE_MAX);
    logic [7:0] r_cnt;
    // saturating wait counter, cleared whenever VGA is served or stops asking
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_cnt <= 8'd0;
        else r_cnt <= (!i_vga_req || i_vga_gnt) ? 8'd0 : (r_cnt == MAX) ? r_cnt : r_cnt + 8'd1;
    end
    assign o_force_vga = (r_cnt == MAX);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between CPU (priority) and VGA reader
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic           clock,
    input  logic           resetn,
    dmem_arbiter_if.slave  bus
);
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
        $error("STARVE_MAX out of range 1..255");
    end
    logic              w_force_vga;
    logic              w_vga_win;
    logic              w_cpu_win;
    logic [ADDR_W-1:0] w_mem_addr;
    owner_e            w_owner_d;
    owner_e            r_owner_q;
`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clock       (clock),
        .resetn      (resetn),
        .i_vga_req   (bus.vga_req),
        .i_vga_gnt   (w_vga_win),
        .o_force_vga (w_force_vga)
    );
`else
    assign w_force_vga = 1'b0;
`endif
    // pick the winner and steer the memory port and the return tag
    always_comb begin
        w_vga_win  = bus.vga_req && (w_force_vga || !bus.cpu_req);
        w_cpu_win  = bus.cpu_req && !w_vga_win;
        w_mem_addr = w_vga_win ? bus.vga_addr : w_cpu_win ? bus.cpu_addr : '0;
        w_owner_d  = w_vga_win ? OWN_VGA : (w_cpu_win && !bus.cpu_wren) ? OWN_CPU : OWN_NONE;
    end
    // remember who issued the read so next cycle's mem_q goes only to them
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_owner_q <= OWN_NONE;
        else r_owner_q <= w_owner_d;
    end
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_data   = bus.cpu_wdata;
    assign bus.mem_wren   = w_cpu_win && bus.cpu_wren;
    assign bus.vga_gnt    = w_vga_win;
    assign bus.cpu_stall  = bus.cpu_req && w_vga_win;
    assign bus.cpu_rdata  = bus.mem_q;
    assign bus.vga_rdata  = bus.mem_q;
    assign bus.cpu_rvalid = (r_owner_q == OWN_CPU);
    assign bus.vga_rvalid = (r_owner_q == OWN_VGA);
endmodule
